switch_output_port: RTL

//  Downstream neighbour of the per-output allocator in the 4x4 butterfly switch.
//  - Consumes the allocator's one-hot select and shift.
//  - Muxes the chosen input phit and strips the two consumed route bits on head phits.
//  - Buffers phits in a small FIFO and presents them to the next hop under a valid/ready handshake.
//  - One instance per output port.

---
 rtl/switch_output_port_pkg.sv | 23 ++
 rtl/switch_output_port_if.sv | 36 +++
 rtl/switch_output_port_fifo.sv | 53 +++++
 rtl/switch_output_port.sv | 75 +++++++
 4 files changed

// File: rtl/switch_output_port_pkg.sv
// Shared constants and types for the butterfly switch output port.
//   NPORTS     : number of switch inputs feeding one output port
//   ROUTE_BITS : route bits consumed per hop on head phits
//   PHIT_W     : phit width; the route field sits in the top bits
//   DEPTH      : output FIFO entries (power of two, >= 2)
//   onehot_chk : true when exactly one bit of a select vector is set
package switch_output_port_pkg;

    localparam int NPORTS     = 4;
    localparam int ROUTE_BITS = 2;
    localparam int PHIT_W     = 16;
    localparam int DEPTH      = 4;
    localparam int PTR_W      = $clog2(DEPTH);
    localparam int CNT_W      = PTR_W + 1;

    typedef logic [PHIT_W-1:0] phit_t;

    // Non-zero and clearing the lowest set bit leaves nothing behind.
    function automatic logic onehot_chk(input logic [NPORTS-1:0] sel);
        return (sel != '0) && ((sel & (sel - NPORTS'(1))) == '0);
    endfunction

endpackage

// File: rtl/switch_output_port_if.sv
// Bundle between the allocator/input side, the next hop and the output port.
//   select, shift, p[]  : allocator grant, head-phit shift flag, input phits
//   out_ready           : next hop accepts phit this cycle
//   phit, valid         : FIFO head presented to the next hop
//   ready               : FIFO has space; fed back to allocator/inputs
//   overflow, sel_err   : sticky error flags
//   count               : FIFO occupancy, exposed for observation
// Handshake: a phit moves to the next hop on every rising clk where
// valid && out_ready; valid and ready come only from registered state, so
// neither depends combinationally on out_ready or select. A one-hot select
// is a write offer that is taken only when ready is high.
// slave is the output port's view; master is the driving/observing side.
interface switch_output_port_if
    import switch_output_port_pkg::*;
    ;
    logic [NPORTS-1:0]   select;
    logic                shift;
    phit_t [NPORTS-1:0]  p;
    logic                out_ready;
    phit_t               phit;
    logic                valid;
    logic                ready;
    logic                overflow;
    logic                sel_err;
    logic [CNT_W-1:0]    count;

    modport master (
        output select, shift, p, out_ready,
        input  phit, valid, ready, overflow, sel_err, count
    );

    modport slave (
        input  select, shift, p, out_ready,
        output phit, valid, ready, overflow, sel_err, count
    );
endinterface

// File: rtl/switch_output_port_fifo.sv
// DEPTH x PHIT_W phit FIFO with occupancy count.
//   clk, rst     : clock, asynchronous active-high reset
//   wr, wdata    : push (caller guarantees !full)
//   rd           : pop head (caller guarantees !empty)
//   rdata        : current head entry
//   count        : occupancy 0..DEPTH
//   full, empty  : derived from count
module switch_output_port_fifo
    import switch_output_port_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  phit_t            wdata,
    input  logic             rd,
    output phit_t            rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    phit_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage is cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr, rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/switch_output_port.sv
// One output port of the 4x4 butterfly switch. Muxes the granted input phit,
// strips the consumed route bits on head phits, buffers it in a small FIFO and
// presents it to the next hop under valid/ready.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave view of switch_output_port_if (grant, phits, handshake,
//              sticky overflow / select-error flags, occupancy)
module switch_output_port
    import switch_output_port_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    switch_output_port_if.slave   bus
);
    logic             sel_onehot;
    logic             sel_multi;
    phit_t            phit_in;
    phit_t            stored;
    logic             wr;
    logic             rd;
    logic             full;
    logic             empty;
    logic             overflow_q;
    logic             sel_err_q;
    phit_t            head;
    logic [CNT_W-1:0] count;

    assign sel_onehot = onehot_chk(bus.select);
    assign sel_multi  = (bus.select != '0) && !sel_onehot;

    // OR-mux; only meaningful for one-hot select, which is all that is written.
    always_comb begin
        phit_in = '0;
        for (int k = 0; k < NPORTS; k++) begin
            if (bus.select[k]) begin
                phit_in = phit_in | bus.p[k];
            end
        end
    end

    assign stored = bus.shift ? {phit_in[PHIT_W-1-ROUTE_BITS:0], {ROUTE_BITS{1'b0}}}
                              : phit_in;

    assign wr = sel_onehot && !full;
    assign rd = !empty && bus.out_ready;

    switch_output_port_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (wr),
        .wdata (stored),
        .rd    (rd),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // A pop in the same cycle does not make room: ready was already low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
            sel_err_q  <= 1'b0;
        end else begin
            overflow_q <= overflow_q | (sel_onehot && full);
            sel_err_q  <= sel_err_q  | sel_multi;
        end
    end

    assign bus.phit     = head;
    assign bus.valid    = !empty;
    assign bus.ready    = !full;
    assign bus.overflow = overflow_q;
    assign bus.sel_err  = sel_err_q;
    assign bus.count    = count;
endmodule
